// File: rtl/ps2_kbd_intc.sv
// ps2_kbd_intc: PS/2 keyboard receiver with scancode FIFO and CPU interrupt source.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   ps2_clk, ps2_data   raw PS/2 pins (asynchronous, synchronised here)
//   address, wdata      CPU word address and write data
//   memwt               CPU write strobe
//   intack              CPU interrupt acknowledge; VECTOR is driven on rdata
//   rdata, sel          read data and bus-mux select (combinational)
//   INT                 level interrupt request: ie & FIFO not empty
//
// Register map: BASE_ADDR = DATA (read head, write pops),
//               BASE_ADDR+1 = STATUS (read) / CTRL (write).
module ps2_kbd_intc #(
   parameter logic [11:0] BASE_ADDR      = 12'h7F0,
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter logic [15:0] VECTOR         = 16'h0001,
   parameter int unsigned TIMEOUT_CYCLES = 10000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   input  logic [11:0] address,
   input  logic [15:0] wdata,
   input  logic        memwt,
   input  logic        intack,
   output logic [15:0] rdata,
   output logic        sel,
   output logic        INT
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [11:0] STAT_ADDR = BASE_ADDR + 12'd1;
   localparam logic [AW:0] FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

   // ---------------------------------------------------------------- pin sync
   logic [1:0] clk_sync;
   logic [1:0] data_sync;
   logic       clk_prev;
   logic       fall;
   logic       bit_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         clk_prev  <= clk_sync[1];
      end
   end

   assign fall   = clk_prev & ~clk_sync[1];
   assign bit_in = data_sync[1];

   // ---------------------------------------------------------------- receiver
   rx_state_e       state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            par_q, par_d;
   logic [TW-1:0]   idle_cnt_q, idle_cnt_d;
   logic            rx_push;
   logic            rx_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         idle_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      idle_cnt_d = idle_cnt_q;
      rx_push    = 1'b0;
      rx_err     = 1'b0;

      // Watchdog only runs inside a frame; any clock edge restarts it.
      if (state_q == StIdle || fall) begin
         idle_cnt_d = '0;
      end else if (idle_cnt_q == TW'(TIMEOUT_CYCLES)) begin
         idle_cnt_d = '0;
         state_d    = StIdle;
         rx_err     = 1'b1;
      end else begin
         idle_cnt_d = idle_cnt_q + TW'(1);
      end

      if (fall) begin
         case (state_q)
            StIdle: begin
               if (!bit_in) begin
                  state_d   = StData;
                  bit_cnt_d = '0;
               end
            end
            StData: begin
               shift_d   = {bit_in, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = StParity;
            end
            StParity: begin
               par_d   = bit_in;
               state_d = StStop;
            end
            StStop: begin
               // Odd parity over data+parity, and stop bit must be 1.
               if ((^{shift_q, par_q}) && bit_in) rx_push = 1'b1;
               else                                rx_err  = 1'b1;
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // ---------------------------------------------------------------- FIFO
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          empty, full;
   logic          data_hit, stat_hit;
   logic          pop, push, ovr_set, ctrl_wr;
   logic          ie_q, ovr_q, ferr_q;

   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_CNT);
   assign data_hit = (address == BASE_ADDR);
   assign stat_hit = (address == STAT_ADDR);
   assign ctrl_wr  = memwt & stat_hit;
   assign pop      = memwt & data_hit & ~empty;
   // A simultaneous pop frees the slot, so a push into a full FIFO is accepted.
   assign push     = rx_push & (~full | pop);
   assign ovr_set  = rx_push & full & ~pop;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= shift_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ie_q     <= 1'b0;
         ovr_q    <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push && !pop)      count_q <= count_q + (AW + 1)'(1);
         else if (pop && !push) count_q <= count_q - (AW + 1)'(1);
         if (ctrl_wr) ie_q <= wdata[0];
         // Set wins over a same-cycle clear.
         ovr_q  <= ovr_set | (ovr_q & ~(ctrl_wr & wdata[1]));
         ferr_q <= rx_err  | (ferr_q & ~(ctrl_wr & wdata[2]));
      end
   end

   logic unused_wdata;
   assign unused_wdata = ^wdata[15:3];

   // ---------------------------------------------------------------- bus side
   logic [15:0] cnt_ext;
   logic [15:0] status;

   assign cnt_ext = 16'(count_q);

   always_comb begin
      status       = '0;
      status[0]    = empty;
      status[1]    = full;
      status[2]    = ie_q;
      status[3]    = ovr_q;
      status[4]    = ferr_q;
      status[11:8] = cnt_ext[3:0];
   end

   always_comb begin
      rdata = '0;
      sel   = 1'b0;
      if (intack) begin
         rdata = VECTOR;
         sel   = 1'b1;
      end else if (data_hit) begin
         sel = 1'b1;
         if (!empty) rdata = {8'h00, mem[rd_ptr_q]};
      end else if (stat_hit) begin
         sel   = 1'b1;
         rdata = status;
      end
   end

   assign INT = ie_q & ~empty;

endmodule

// File: tb/tb_ps2_kbd_intc.sv
// Directed bench for ps2_kbd_intc: PS/2 frames driven on the pins, CPU bus
// reads/writes, hand-computed expected register values.
module tb_ps2_kbd_intc;

   localparam logic [11:0] DATA_A = 12'h7F0;
   localparam logic [11:0] STAT_A = 12'h7F1;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        ps2_clk  = 1'b1;
   logic        ps2_data = 1'b1;
   logic [11:0] address  = '0;
   logic [15:0] wdata    = '0;
   logic        memwt    = 1'b0;
   logic        intack   = 1'b0;
   logic [15:0] rdata;
   logic        sel;
   logic        INT;

   int tests = 0;
   int fails = 0;

   ps2_kbd_intc dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .address  (address),
      .wdata    (wdata),
      .memwt    (memwt),
      .intack   (intack),
      .rdata    (rdata),
      .sel      (sel),
      .INT      (INT)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reg(input string tag, input logic [11:0] a, input logic [15:0] exp);
      address = a;
      #1;
      check(tag, rdata, exp);
   endtask

   task automatic wr(input logic [11:0] a, input logic [15:0] d);
      address = a;
      wdata   = d;
      memwt   = 1'b1;
      step();
      memwt   = 1'b0;
      wdata   = '0;
   endtask

   // Pin edge lands at posedge+2; the receiver acts on the 3rd posedge after it,
   // so pop_on_fall asserts the DATA write strobe for exactly that edge.
   task automatic send_bit(input logic b, input logic pop_on_fall);
      ps2_data = b;
      repeat (4) step();
      ps2_clk = 1'b0;
      if (pop_on_fall) begin
         repeat (2) step();
         address = DATA_A;
         memwt   = 1'b1;
         step();
         memwt   = 1'b0;
         step();
      end else begin
         repeat (4) step();
      end
      ps2_clk = 1'b1;
      repeat (4) step();
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                             input logic pop_on_stop);
      logic p;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
      p = (~^b) ^ bad_par;
      send_bit(p, 1'b0);
      send_bit(stop, pop_on_stop);
   endtask

   initial begin
      // Reset state
      repeat (3) step();
      check_reg("rst_status", STAT_A, 16'h0001);
      check("rst_int", {15'd0, INT}, 16'h0000);
      rst_n = 1'b1;
      step();
      check_reg("rst_data_empty", DATA_A, 16'h0000);
      check("rst_data_sel", {15'd0, sel}, 16'h0001);
      address = 12'h123;
      #1;
      check("miss_sel", {15'd0, sel}, 16'h0000);
      check("miss_rdata", rdata, 16'h0000);

      // Enable interrupts, receive 0x1C
      wr(STAT_A, 16'h0001);
      check_reg("ie_status", STAT_A, 16'h0005);
      check("int_before_frame", {15'd0, INT}, 16'h0000);
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      check_reg("1c_status", STAT_A, 16'h0104);
      check("1c_int", {15'd0, INT}, 16'h0001);
      check_reg("1c_data", DATA_A, 16'h001C);

      // Interrupt acknowledge
      address = 12'h000;
      intack  = 1'b1;
      #1;
      check("ack_rdata", rdata, 16'h0001);
      check("ack_sel", {15'd0, sel}, 16'h0001);
      step();
      intack = 1'b0;
      check_reg("ack_no_pop", STAT_A, 16'h0104);
      check("ack_int_held", {15'd0, INT}, 16'h0001);
      wr(DATA_A, 16'hBEEF);
      check_reg("pop_status", STAT_A, 16'h0005);
      check("pop_int", {15'd0, INT}, 16'h0000);

      // Framing errors
      send_frame(8'h55, 1'b1, 1'b1, 1'b0);
      check_reg("badpar_status", STAT_A, 16'h0015);
      wr(STAT_A, 16'h0005);
      check_reg("ferr_clr1", STAT_A, 16'h0005);
      send_frame(8'h33, 1'b0, 1'b0, 1'b0);
      check_reg("badstop_status", STAT_A, 16'h0015);
      wr(STAT_A, 16'h0004);
      check_reg("ferr_clr2", STAT_A, 16'h0001);
      wr(STAT_A, 16'h0001);

      // Overflow: 9 frames into 8 entries
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
      check_reg("ovf_status", STAT_A, 16'h080E);
      check_reg("ovf_head", DATA_A, 16'h0001);
      check("ovf_int", {15'd0, INT}, 16'h0001);
      for (int i = 1; i <= 8; i++) begin
         check_reg($sformatf("drain_%0d", i), DATA_A, 16'(i));
         wr(DATA_A, 16'h0000);
      end
      check_reg("drained_status", STAT_A, 16'h000D);
      wr(STAT_A, 16'h0003);
      check_reg("ovr_clr", STAT_A, 16'h0005);

      // Full FIFO with pop on the same edge as the stop-bit push
      for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1, 1'b0);
      check_reg("full_status", STAT_A, 16'h0806);
      send_frame(8'h18, 1'b0, 1'b1, 1'b1);
      check_reg("pushpop_status", STAT_A, 16'h0806);
      for (int i = 1; i <= 8; i++) begin
         check_reg($sformatf("pp_drain_%0d", i), DATA_A, 16'h0010 + 16'(i));
         wr(DATA_A, 16'h0000);
      end
      check_reg("pp_empty", STAT_A, 16'h0005);

      // Timeout on a partial frame
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      repeat (9000) step();
      check_reg("to_not_yet", STAT_A, 16'h0005);
      repeat (1100) step();
      check_reg("to_status", STAT_A, 16'h0015);
      wr(STAT_A, 16'h0005);
      send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
      check_reg("to_f0_status", STAT_A, 16'h0104);
      check_reg("to_f0_data", DATA_A, 16'h00F0);

      // Reset mid-frame with three entries queued
      send_frame(8'h21, 1'b0, 1'b1, 1'b0);
      send_frame(8'h22, 1'b0, 1'b1, 1'b0);
      check_reg("pre_rst_status", STAT_A, 16'h0304);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_int", {15'd0, INT}, 16'h0000);
      check_reg("midrst_status", STAT_A, 16'h0001);
      step();
      rst_n = 1'b1;
      step();
      check_reg("post_rst_status", STAT_A, 16'h0001);
      check_reg("post_rst_data", DATA_A, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
